// File: rtl/pipe_mem_pkg.sv
// Shared types for the unified memory arbiter: FSM states, port identifiers
// and default bus widths.
package pipe_mem_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arb_state_e;

  typedef enum logic {
    PORT_IF,
    PORT_D
  } port_e;

endpackage

// File: rtl/starve_arbiter.sv
// Priority decision between fetch and data requests. Data normally wins; after
// STARVE_MAX consecutive lost arbitrations fetch is guaranteed the next grant.
module starve_arbiter
  import pipe_mem_pkg::*;
#(
  parameter int STARVE_MAX = 2,
  parameter int CW         = $clog2(STARVE_MAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          arb_en,
  input  logic          if_req,
  input  logic          d_req,
  output port_e         grant,
  output logic [CW-1:0] starve_cnt
);

  logic fetch_wins;

  assign fetch_wins = if_req & (~d_req | (starve_cnt == CW'(STARVE_MAX)));
  assign grant      = fetch_wins ? PORT_IF : PORT_D;

  // Count only data grants that left a waiting fetch behind; anything else resets.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (arb_en) begin
      if (grant == PORT_D && if_req) begin
        if (starve_cnt != CW'(STARVE_MAX)) starve_cnt <= starve_cnt + CW'(1);
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store:
// grant in IDLE, one-cycle issue, fixed-latency wait, one-cycle done pulse.
module unified_mem_arbiter
  import pipe_mem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               if_req,
  input  logic [ADDR_W-1:0]                  if_addr,
  output logic [DATA_W-1:0]                  if_rdata,
  output logic                               if_done,
  input  logic                               d_req,
  input  logic                               d_we,
  input  logic [ADDR_W-1:0]                  d_addr,
  input  logic [DATA_W-1:0]                  d_wdata,
  output logic [DATA_W-1:0]                  d_rdata,
  output logic                               d_done,
  output logic                               stall_if,
  output logic                               stall_mem,
  output logic                               mem_en,
  output logic                               mem_we,
  output logic [ADDR_W-1:0]                  mem_addr,
  output logic [DATA_W-1:0]                  mem_wdata,
  input  logic [DATA_W-1:0]                  mem_rdata,
  output arb_state_e                         dbg_state,
  output logic [$clog2(STARVE_MAX+1)-1:0]    dbg_starve_cnt
);

  localparam int LW = $clog2(MEM_LAT + 1);

  // Handshake: a requester raises req with stable address/data and holds it until
  // its done pulse; requests are sampled only while IDLE, and the cycle after done
  // the requester either drops req or presents a fresh request.

  arb_state_e      state, next_state;
  logic [LW-1:0]   lat_cnt;
  port_e           sel_port;
  logic            sel_we;
  logic            arb_en;
  port_e           grant;

  assign arb_en    = (state == IDLE) & (if_req | d_req);
  assign stall_if  = ~reset & if_req & ~if_done;
  assign stall_mem = ~reset & d_req & ~d_done;
  assign dbg_state = state;

  starve_arbiter #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_arbiter (
    .clk        (clk),
    .reset      (reset),
    .arb_en     (arb_en),
    .if_req     (if_req),
    .d_req      (d_req),
    .grant      (grant),
    .starve_cnt (dbg_starve_cnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (if_req | d_req) next_state = ISSUE;
      ISSUE:   next_state = WAIT;
      WAIT:    if (lat_cnt == LW'(1)) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The mem_* registers double as the request latch: loaded at the grant edge so
  // they are already driven during the ISSUE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_cnt   <= '0;
      sel_port  <= PORT_IF;
      sel_we    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_done   <= 1'b0;
      d_done    <= 1'b0;
    end else begin
      mem_en  <= 1'b0;
      if_done <= 1'b0;
      d_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_en) begin
            sel_port <= grant;
            mem_en   <= 1'b1;
            if (grant == PORT_D) begin
              sel_we    <= d_we;
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
            end else begin
              sel_we    <= 1'b0;
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
            end
          end
        end
        ISSUE: begin
          lat_cnt <= LW'(MEM_LAT);
          mem_we  <= 1'b0;
        end
        WAIT: begin
          lat_cnt <= lat_cnt - LW'(1);
          if (lat_cnt == LW'(1)) begin
            if (sel_port == PORT_IF) begin
              if_rdata <= mem_rdata;
              if_done  <= 1'b1;
            end else begin
              if (!sel_we) d_rdata <= mem_rdata;
              d_done <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Sequences and shares one single-port unified memory between the pipeline's instruction-fetch (IF) stage and its load/store (MEM) stage. Each transaction is issued to the memory, waited on for a fixed read latency, and completed with a one-cycle done pulse. The block also produces the stage stall signals. Data accesses have priority, and a starvation counter guarantees forward progress for fetch.

## Interface
Parameters:
- ADDR_W, 32, byte-address width
- DATA_W, 32, data width
- MEM_LAT, 1, cycles from mem_en to valid mem_rdata (≥1)
- STARVE_MAX, 2, consecutive lost arbitrations after which fetch wins (≥1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- if_req  in  1  fetch request, level, held until if_done
- if_addr  in  ADDR_W  fetch byte address
- if_rdata  out  DATA_W  fetched word
- if_done  out  1  one-cycle completion pulse
- d_req  in  1  data request, level, held until d_done
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load result
- d_done  out  1  one-cycle completion pulse
- stall_if  out  1  if_req & ~if_done, forced 0 during reset
- stall_mem  out  1  d_req & ~d_done, forced 0 during reset
- mem_en  out  1  memory access strobe, exactly one cycle per transaction
- mem_we  out  1  write strobe, qualified by mem_en
- mem_addr  out  ADDR_W  byte address, passed through unchanged
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  valid MEM_LAT cycles after the mem_en cycle

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE:** evaluated at the clock edge. If any request is high, the arbiter grants, latches the port, addr, we and wdata, and moves to ISSUE. Otherwise it stays in IDLE.
- **Grant rule:**
  - d_req alone → data.
  - if_req alone → fetch.
  - Both high → data, unless starve_cnt == STARVE_MAX, in which case fetch wins.
- **starve_cnt:**
  - +1 (saturating at STARVE_MAX) on a data grant while if_req is high.
  - Cleared on a fetch grant, or when if_req is low at an arbitration.
- **ISSUE:** mem_en=1, with mem_we/mem_addr/mem_wdata taken from the latched values. The lat counter loads MEM_LAT. Next state is WAIT.
- **WAIT:** the counter decrements each cycle. On the cycle where it reaches 1 (mem_rdata valid), the block captures mem_rdata into the served port's rdata register, for loads/fetches only, and moves to DONE.
- **DONE:** pulses the served port's done. Next state is always IDLE.
- **Requester obligations:** in the cycle after done, the requester drops req or presents a new request. Request inputs are ignored outside IDLE; changes mid-transaction have no effect.
- **Stores:** take the same path and latency as loads. d_rdata is unchanged.
- **rdata holding:** if_rdata and d_rdata hold their value until that port's next read completes.
- **Reset, applied at any time:**
  - State → IDLE, starve_cnt=0, counter=0.
  - mem_en/mem_we/mem_addr/mem_wdata=0; if_rdata/d_rdata=0; if_done/d_done=0.
  - An in-flight transaction is dropped. A late mem_rdata is ignored and no done pulse is produced.

## Timing
- **Single transaction:** request seen in cycle 0 (IDLE) → mem_en in cycle 1 → mem_rdata valid in cycle 1+MEM_LAT → done in cycle 2+MEM_LAT.
- **Back-to-back:** the next grant happens at the IDLE cycle 3+MEM_LAT, giving a throughput of one transaction per MEM_LAT+3 cycles.
- **Registered outputs:** mem_* and *_rdata/*_done are registered. stall_* are combinational.

## Structure
- **Package pipe_mem_pkg:**
  - arb_state_e {IDLE, ISSUE, WAIT, DONE}
  - port_e {PORT_IF, PORT_D}
  - Default widths ADDR_W/DATA_W.
- **Sub-module starve_arbiter:** holds the priority decision and the starve_cnt register. Inputs: clk, reset, arb_en, if_req, d_req. Output: grant (port_e).
- **Top level:** FSM, latency counter ($clog2(MEM_LAT+1) bits), request latches and output registers.

## Test plan
All scenarios use MEM_LAT=1, STARVE_MAX=2.
- **Reset:** hold reset with both requests high → all outputs 0, stall_if=stall_mem=0; no mem_en for 2 cycles after release unless a request is present.
- **Fetch read:**
  - Stimulus: if_req with if_addr=0x8 in cycle 0; memory returns 0x00A00093 in cycle 2.
  - Required: mem_en=1 only in cycle 1 with mem_addr=0x8; if_done in cycle 3 with if_rdata=0x00A00093; stall_if=1 in cycles 0–2.
- **Simultaneous requests:**
  - Stimulus: if_req (0x0) and load d_req (0x10) in cycle 0.
  - Required: data mem_en in cycle 1, d_done in cycle 3; fetch mem_en in cycle 5, if_done in cycle 7.
- **Starvation:**
  - Stimulus: if_req held from cycle 0; d_req re-asserted in every IDLE.
  - Required: data granted with mem_en in cycles 1 and 5; fetch mem_en in cycle 9, if_done in cycle 11; starve_cnt back to 0.
- **Store:**
  - Stimulus: d_req, d_we=1, d_addr=0x14, d_wdata=0x2A.
  - Required: mem_en=mem_we=1 in cycle 1 with mem_wdata=0x2A; d_done in cycle 3; d_rdata unchanged.
- **Reset mid-operation:**
  - Stimulus: reset asserted during the WAIT cycle of a load.
  - Required: all outputs 0 immediately; no d_done even though mem_rdata arrives; a new load issued after release completes in the normal 3 cycles.
